// File: rtl/serial_pkg.sv
// Shared definitions for serial_tx_piso: frame state encoding and the default word width.
package serial_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int STATE_W    = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // The bit counter must be able to hold the value DATA_W itself.
  function automatic int cnt_width(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/dff_are.sv
// Single D flip-flop with active-low asynchronous reset to a selectable value.
module dff_are #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic C,
  input  logic RE,
  input  logic D,
  output logic Q
);

  // NOTE: sequential state is assigned with non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge C or negedge RE) begin
    if (!RE) Q <= RST_VAL;
    else     Q <= D;
  end

endmodule

// File: rtl/serial_tx_piso.sv
// Parallel-in serial-out transmitter: start bit, DATA_W bits LSB first, optional even parity, stop bit.
// Define SERIAL_TX_PARITY_EN to insert the parity bit between the data bits and the stop bit.
module serial_tx_piso
  import serial_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              C,
  input  logic              RE,
  input  logic              LOAD,
  input  logic [DATA_W-1:0] DIN,
  output logic              SOUT,
  output logic              READY,
  output logic              DONE
);

  localparam int CNT_W = cnt_width(DATA_W);

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d_bits;
  state_t             state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic               sout_q, sout_d;
  logic               ready_q, ready_d;
  logic               done_q, done_d;
`ifdef SERIAL_TX_PARITY_EN
  logic               par_q, par_d;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = ST_IDLE;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    sout_d  = 1'b1;
    ready_d = 1'b0;
    done_d  = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (LOAD) begin
          state_d = ST_START;
          shift_d = DIN;
          cnt_d   = '0;
          sout_d  = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
          par_d   = ^DIN;
`endif
        end else begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
        end
      end
      ST_START: begin
        state_d = ST_DATA;
        sout_d  = shift_q[0];
        shift_d = shift_q >> 1;
        cnt_d   = CNT_W'(1);
      end
      ST_DATA: begin
        // cnt_q counts bits already on the line; the last one has been out for a full cycle at DATA_W.
        if (cnt_q == CNT_W'(DATA_W)) begin
`ifdef SERIAL_TX_PARITY_EN
          state_d = ST_PARITY;
          sout_d  = par_q;
`else
          state_d = ST_STOP;
          done_d  = 1'b1;
`endif
        end else begin
          state_d = ST_DATA;
          sout_d  = shift_q[0];
          shift_d = shift_q >> 1;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      ST_PARITY: begin
        state_d = ST_STOP;
        done_d  = 1'b1;
      end
`endif
      ST_STOP: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
        cnt_d   = '0;
        shift_d = '0;
      end
    endcase
  end

  assign state_d_bits = state_d;

  for (genvar i = 0; i < STATE_W; i++) begin : g_state
    dff_are #(.RST_VAL(1'b0)) u_ff (.C(C), .RE(RE), .D(state_d_bits[i]), .Q(state_q[i]));
  end

  for (genvar i = 0; i < CNT_W; i++) begin : g_cnt
    dff_are #(.RST_VAL(1'b0)) u_ff (.C(C), .RE(RE), .D(cnt_d[i]), .Q(cnt_q[i]));
  end

  for (genvar i = 0; i < DATA_W; i++) begin : g_shift
    dff_are #(.RST_VAL(1'b0)) u_ff (.C(C), .RE(RE), .D(shift_d[i]), .Q(shift_q[i]));
  end

`ifdef SERIAL_TX_PARITY_EN
  dff_are #(.RST_VAL(1'b0)) u_par_ff   (.C(C), .RE(RE), .D(par_d),   .Q(par_q));
`endif
  // The line and READY idle high, so those two flops reset to 1.
  dff_are #(.RST_VAL(1'b1)) u_sout_ff  (.C(C), .RE(RE), .D(sout_d),  .Q(sout_q));
  dff_are #(.RST_VAL(1'b1)) u_ready_ff (.C(C), .RE(RE), .D(ready_d), .Q(ready_q));
  dff_are #(.RST_VAL(1'b0)) u_done_ff  (.C(C), .RE(RE), .D(done_d),  .Q(done_q));

  assign SOUT  = sout_q;
  assign READY = ready_q;
  assign DONE  = done_q;

endmodule
